riscv_core_lsu: RTL and testbench
=================================

# riscv_core_lsu

Load/store unit for the RV64I core: accepts one memory access at a time from the execute stage and drives the doubleword-wide data-memory bus. For stores it generates byte enables and lane-shifted write data. For loads it right-aligns the returned doubleword into raw load data. That raw data, with the registered size and sign/zero-extend select, feeds the load-extend stage directly downstream.

## Interface
Parameters:
- XLEN, 64, data and address width; this block supports only 64 (8 byte lanes).

Ports:
- i_lsu_clk  in  1  clock; single clock domain.
- i_lsu_rst  in  1  reset; synchronous, active-high.
- i_lsu_valid  in  1  access request from execute stage.
- o_lsu_ready  out  1  high only in IDLE; request accepted when valid & ready.
- i_lsu_we  in  1  1 = store, 0 = load.
- i_lsu_su_extend  in  1  0 = sign-extend, 1 = zero-extend; passed through for loads.
- i_lsu_r_w_size  in  2  00 byte, 01 half, 10 word, 11 double.
- i_lsu_addr  in  XLEN  byte address.
- i_lsu_wdata  in  XLEN  store data, right-aligned.
- o_lsu_mem_req  out  1  bus request; held high until granted.
- i_lsu_mem_gnt  in  1  bus grant.
- o_lsu_mem_addr  out  XLEN  access address with [2:0] forced to 0.
- o_lsu_mem_we  out  1  bus write enable.
- o_lsu_mem_be  out  8  byte enables.
- o_lsu_mem_wdata  out  XLEN  lane-shifted store data.
- i_lsu_mem_rvalid  in  1  load data valid.
- i_lsu_mem_rdata  in  XLEN  load doubleword.
- o_lsu_done  out  1  one-cycle completion pulse.
- o_lsu_misaligned  out  1  one-cycle misaligned-access pulse; no bus activity.
- o_lsu_rdata  out  XLEN  right-aligned raw load data to load-extend.
- o_lsu_su_extend  out  1  registered extend select to load-extend.
- o_lsu_r_w_size  out  2  registered size to load-extend.

## Operation
- On acceptance, register we, su_extend, size, addr, wdata. Let off = addr[2:0].
- Misaligned condition:
  - half: off[0] != 0
  - word: off[1:0] != 0
  - double: off != 0
  - byte: never misaligned.
- Byte enables: byte 8'h01<<off, half 8'h03<<off, word 8'h0F<<off, double 8'hFF.
- mem_wdata = wdata << (8*off). Lanes not covered by be are don't-care.
- Load result: o_lsu_rdata = i_lsu_mem_rdata >> (8*off), logical shift with zero fill. It is captured on rvalid in WAIT and held until the next load completes.
- o_lsu_su_extend and o_lsu_r_w_size update on every accepted request, including stores.
- FSM states:
  - IDLE: ready=1. valid & aligned goes to REQ. valid & misaligned goes to ERR.
  - REQ: mem_req=1, with addr, we, be and wdata stable. On gnt, a store goes to DONE and a load goes to WAIT. With no gnt, stay in REQ.
  - WAIT: on rvalid, capture data and go to DONE. Otherwise stay in WAIT.
  - DONE: o_lsu_done=1 for one cycle, then go to IDLE.
  - ERR: o_lsu_misaligned=1 for one cycle, then go to IDLE. mem_req stays 0.
- rvalid is ignored in IDLE, REQ, DONE and ERR. A stale response never updates o_lsu_rdata.

## Timing
- Reset values:
  - state IDLE, so o_lsu_ready=1.
  - o_lsu_mem_req, o_lsu_mem_we, o_lsu_done and o_lsu_misaligned are 0.
  - o_lsu_mem_be=0; o_lsu_mem_addr, o_lsu_mem_wdata and o_lsu_rdata are 0.
  - o_lsu_su_extend=0, o_lsu_r_w_size=0.
- All bus outputs are registered. A request accepted at edge T gives mem_req high in cycle T+1.
- Store with immediate gnt: done high in cycle T+2. Each cycle without gnt adds 1.
- Load: rvalid is never earlier than the cycle after gnt. Minimum latency is done in cycle T+3, with o_lsu_rdata valid in the same cycle as done.
- Misaligned: misaligned high in cycle T+1, ready again in T+2.
- Throughput: at most one access per 3 cycles (store) or 4 cycles (load).
- Reset mid-operation: the FSM returns to IDLE at the next edge and mem_req drops in the same cycle. A later orphan rvalid is ignored.
- valid while not ready is ignored. The upstream stage holds the request until accepted.

## Test plan
- Store byte, addr=0x1003, wdata=0xAB, gnt in the first REQ cycle:
  - mem_addr=0x1000, be=8'h08, wdata[31:24]=0xAB.
  - done pulses exactly 2 cycles after acceptance.
- Load word, addr=0x2004, su_extend=0, gnt delayed 3 cycles, rvalid 2 cycles after gnt, rdata=0x8765_4321_0000_0000:
  - o_lsu_rdata=0x0000_0000_8765_4321, o_lsu_r_w_size=10, o_lsu_su_extend=0.
  - mem_req is held through the gnt stall.
- Misaligned half at addr=0x11, and double at addr=0x8004:
  - misaligned pulses 1 cycle and done stays 0.
  - mem_req is never asserted and ready returns 2 cycles after acceptance.
- Load double at addr=0x3000, rdata=0xFFFF_0000_1234_5678: o_lsu_rdata is equal to rdata and be=8'hFF.
- Reset asserted while in WAIT, then rvalid after reset:
  - all outputs are at reset values and o_lsu_rdata is unchanged (0).
  - the next store completes normally.
- Back-to-back requests with valid held high: the second is accepted only after done, with no overlap of mem_req.

Source files
------------

// File: rtl/riscv_core_lsu.sv
// Load/store unit for the RV64I core: one access at a time onto a doubleword data bus.
// Stores get lane-shifted data and byte enables; loads return right-aligned raw data.
module riscv_core_lsu #(
    parameter int XLEN = 64
) (
    input  logic            i_lsu_clk,
    input  logic            i_lsu_rst,
    input  logic            i_lsu_valid,
    output logic            o_lsu_ready,
    input  logic            i_lsu_we,
    input  logic            i_lsu_su_extend,
    input  logic [1:0]      i_lsu_r_w_size,
    input  logic [XLEN-1:0] i_lsu_addr,
    input  logic [XLEN-1:0] i_lsu_wdata,
    output logic            o_lsu_mem_req,
    input  logic            i_lsu_mem_gnt,
    output logic [XLEN-1:0] o_lsu_mem_addr,
    output logic            o_lsu_mem_we,
    output logic [7:0]      o_lsu_mem_be,
    output logic [XLEN-1:0] o_lsu_mem_wdata,
    input  logic            i_lsu_mem_rvalid,
    input  logic [XLEN-1:0] i_lsu_mem_rdata,
    output logic            o_lsu_done,
    output logic            o_lsu_misaligned,
    output logic [XLEN-1:0] o_lsu_rdata,
    output logic            o_lsu_su_extend,
    output logic [1:0]      o_lsu_r_w_size
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_DONE = 3'd3;
    localparam logic [2:0] S_ERR  = 3'd4;

    logic [2:0]      state;
    logic [2:0]      off_q;
    logic [2:0]      off;
    logic            misaligned_c;
    logic [7:0]      be_c;
    logic [XLEN-1:0] wdata_sh;

    assign off      = i_lsu_addr[2:0];
    assign wdata_sh = i_lsu_wdata << {off, 3'b000};

    always_comb begin
        misaligned_c = 1'b0;
        be_c         = '0;
        case (i_lsu_r_w_size)
            2'b00: begin
                misaligned_c = 1'b0;
                be_c         = 8'h01 << off;
            end
            2'b01: begin
                misaligned_c = off[0];
                be_c         = 8'h03 << off;
            end
            2'b10: begin
                misaligned_c = |off[1:0];
                be_c         = 8'h0F << off;
            end
            default: begin
                misaligned_c = |off;
                be_c         = 8'hFF;
            end
        endcase
    end

    // Bus fields are only loaded for aligned accesses, so a misaligned request leaves the bus untouched.
    always_ff @(posedge i_lsu_clk) begin
        if (i_lsu_rst) begin
            state           <= S_IDLE;
            off_q           <= '0;
            o_lsu_mem_addr  <= '0;
            o_lsu_mem_we    <= 1'b0;
            o_lsu_mem_be    <= '0;
            o_lsu_mem_wdata <= '0;
            o_lsu_rdata     <= '0;
            o_lsu_su_extend <= 1'b0;
            o_lsu_r_w_size  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_lsu_valid) begin
                        o_lsu_su_extend <= i_lsu_su_extend;
                        o_lsu_r_w_size  <= i_lsu_r_w_size;
                        off_q           <= off;
                        if (misaligned_c) begin
                            state <= S_ERR;
                        end else begin
                            state           <= S_REQ;
                            o_lsu_mem_addr  <= {i_lsu_addr[XLEN-1:3], 3'b000};
                            o_lsu_mem_we    <= i_lsu_we;
                            o_lsu_mem_be    <= be_c;
                            o_lsu_mem_wdata <= wdata_sh;
                        end
                    end
                end
                S_REQ: begin
                    if (i_lsu_mem_gnt) begin
                        state <= o_lsu_mem_we ? S_DONE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (i_lsu_mem_rvalid) begin
                        o_lsu_rdata <= i_lsu_mem_rdata >> {off_q, 3'b000};
                        state       <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                S_ERR:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign o_lsu_ready      = (state == S_IDLE);
    assign o_lsu_mem_req    = (state == S_REQ);
    assign o_lsu_done       = (state == S_DONE);
    assign o_lsu_misaligned = (state == S_ERR);

endmodule

// File: tb/tb_riscv_core_lsu.sv
// Scoreboard bench for riscv_core_lsu: directed cases plus randomized accesses
// against a byte-lane reference model and a randomized bus responder.
module tb_riscv_core_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid, ready, we, ext, mem_req, gnt, mem_we, rvalid;
    logic        done, mis_o, ext_o;
    logic [1:0]  size, size_o;
    logic [63:0] addr, wdata, mem_addr, mem_wdata, rdata_in, rdata_o;
    logic [7:0]  mem_be;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    int          gnt_delay = 0;
    int          rv_delay = 0;
    logic [63:0] resp_data = '0;
    bit          spurious_en = 1'b0;
    bit          orphan = 1'b0;

    typedef struct {
        bit          mis;
        bit          we;
        bit          ext;
        bit [1:0]    size;
        logic [63:0] rres;
        int          due;
    } txn_t;

    typedef struct {
        logic [63:0] addr;
        bit          we;
        logic [7:0]  be;
        logic [63:0] wl;
    } bus_t;

    txn_t tq[$];
    bus_t bq[$];

    riscv_core_lsu #(.XLEN(64)) dut (
        .i_lsu_clk        (clk),
        .i_lsu_rst        (rst),
        .i_lsu_valid      (valid),
        .o_lsu_ready      (ready),
        .i_lsu_we         (we),
        .i_lsu_su_extend  (ext),
        .i_lsu_r_w_size   (size),
        .i_lsu_addr       (addr),
        .i_lsu_wdata      (wdata),
        .o_lsu_mem_req    (mem_req),
        .i_lsu_mem_gnt    (gnt),
        .o_lsu_mem_addr   (mem_addr),
        .o_lsu_mem_we     (mem_we),
        .o_lsu_mem_be     (mem_be),
        .o_lsu_mem_wdata  (mem_wdata),
        .i_lsu_mem_rvalid (rvalid),
        .i_lsu_mem_rdata  (rdata_in),
        .o_lsu_done       (done),
        .o_lsu_misaligned (mis_o),
        .o_lsu_rdata      (rdata_o),
        .o_lsu_su_extend  (ext_o),
        .o_lsu_r_w_size   (size_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // Reference: an access covers 2**size bytes starting at lane off.
    function automatic void ref_model(input bit [1:0] sz, input logic [63:0] a, input logic [63:0] wd,
                                      input logic [63:0] rd, output bit mis, output logic [7:0] be,
                                      output logic [63:0] wl, output logic [63:0] rres);
        int nb;
        int o;
        nb = 1 << sz;
        o  = int'(a[2:0]);
        mis  = (o % nb) != 0;
        be   = '0;
        wl   = '0;
        rres = '0;
        for (int i = 0; i < nb; i++) begin
            if (o + i < 8) begin
                be[o+i]           = 1'b1;
                wl[8*(o+i) +: 8]  = wd[8*i +: 8];
            end
        end
        for (int i = 0; i + o < 8; i++) rres[8*i +: 8] = rd[8*(i+o) +: 8];
    endfunction

    function automatic logic [63:0] lane_mask(input logic [7:0] be);
        logic [63:0] m;
        m = '0;
        for (int i = 0; i < 8; i++) if (be[i]) m[8*i +: 8] = 8'hFF;
        return m;
    endfunction

    // Bus responder: grant after gnt_delay REQ cycles, load data rv_delay+1 cycles after grant.
    initial begin
        int wcnt;
        int rcnt;
        gnt = 1'b0; rvalid = 1'b0; rdata_in = '0; wcnt = 0; rcnt = -1;
        forever begin
            @(negedge clk); #1;
            gnt = 1'b0; rvalid = 1'b0; rdata_in = {$urandom, $urandom};
            if (rst) begin
                rcnt = -1; wcnt = 0;
            end else begin
                if (orphan) rvalid = 1'b1;
                else if (rcnt == 0) begin rvalid = 1'b1; rdata_in = resp_data; rcnt = -1; end
                else if (rcnt > 0) rcnt--;
                else if (spurious_en && $urandom_range(0, 3) == 0) rvalid = 1'b1;
                if (!mem_req) wcnt = gnt_delay;
                else if (wcnt == 0) begin
                    gnt = 1'b1;
                    if (!mem_we) rcnt = rv_delay;
                    wcnt = gnt_delay;
                end else wcnt--;
            end
        end
    end

    // Monitor: bus fields every REQ cycle, completions against the scoreboard.
    initial begin
        txn_t t;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (mem_req) begin
                    chk("ready_during_req", {63'd0, ready}, 64'd0);
                    if (bq.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL unexpected_mem_req: got 1 expected 0 (cycle %0d)", cyc);
                    end else begin
                        chk("mem_addr", mem_addr, bq[0].addr);
                        chk("mem_we", {63'd0, mem_we}, {63'd0, bq[0].we});
                        chk("mem_be", {56'd0, mem_be}, {56'd0, bq[0].be});
                        chk("mem_wdata", mem_wdata & lane_mask(bq[0].be), bq[0].wl);
                    end
                end
                if (done || mis_o) begin
                    if (tq.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL unexpected_completion: got done=%0b mis=%0b expected none", done, mis_o);
                    end else begin
                        t = tq.pop_front();
                        chk("misaligned", {63'd0, mis_o}, {63'd0, t.mis});
                        chk("done", {63'd0, done}, {63'd0, !t.mis});
                        chk("latency_cycle", 64'(cyc), 64'(t.due));
                        chk("size_out", {62'd0, size_o}, {62'd0, t.size});
                        chk("ext_out", {63'd0, ext_o}, {63'd0, t.ext});
                        if (!t.mis && !t.we) chk("load_rdata", rdata_o, t.rres);
                        if (!t.mis && bq.size() != 0) void'(bq.pop_front());
                    end
                end
            end
        end
    end

    task automatic issue(input bit w, input bit e, input bit [1:0] sz, input logic [63:0] a,
                         input logic [63:0] wd, input logic [63:0] rd, input int gd, input int rdl,
                         input bit hold);
        txn_t t;
        bus_t b;
        bit m;
        logic [7:0] be;
        logic [63:0] wl, rr;
        int n;
        ref_model(sz, a, wd, rd, m, be, wl, rr);
        @(negedge clk);
        valid = 1'b1; we = w; ext = e; size = sz; addr = a; wdata = wd;
        n = 0;
        while (!ready) begin
            @(negedge clk);
            n++;
            if (n > 100) begin
                tests++; fails++;
                $display("FAIL accept_timeout: got ready=0 expected 1");
                valid = 1'b0;
                return;
            end
        end
        gnt_delay = gd; rv_delay = rdl; resp_data = rd;
        @(posedge clk); #1;
        t.mis = m; t.we = w; t.ext = e; t.size = sz; t.rres = rr;
        t.due = cyc + (m ? 0 : (w ? 1 + gd : 2 + gd + rdl));
        tq.push_back(t);
        if (!m) begin
            b.addr = {a[63:3], 3'b000}; b.we = w; b.be = be; b.wl = wl;
            bq.push_back(b);
        end
        if (!hold) valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (tq.size() != 0 || !ready) begin
            @(negedge clk);
            n++;
            if (n > 200) begin
                tests++; fails++;
                $display("FAIL drain_timeout: got %0d pending expected 0", tq.size());
                tq.delete(); bq.delete();
                break;
            end
        end
    endtask

    task automatic check_reset();
        chk("rst_ready", {63'd0, ready}, 64'd1);
        chk("rst_mem_req", {63'd0, mem_req}, 64'd0);
        chk("rst_mem_we", {63'd0, mem_we}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_misaligned", {63'd0, mis_o}, 64'd0);
        chk("rst_mem_be", {56'd0, mem_be}, 64'd0);
        chk("rst_mem_addr", mem_addr, 64'd0);
        chk("rst_mem_wdata", mem_wdata, 64'd0);
        chk("rst_rdata", rdata_o, 64'd0);
        chk("rst_ext", {63'd0, ext_o}, 64'd0);
        chk("rst_size", {62'd0, size_o}, 64'd0);
    endtask

    initial begin
        bit [1:0] sz;
        logic [63:0] a;
        rst = 1'b1; valid = 1'b0; we = 1'b0; ext = 1'b0; size = '0; addr = '0; wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset();

        issue(1'b1, 1'b0, 2'b00, 64'h1003, 64'hAB, 64'h0, 0, 0, 1'b0);
        drain();
        issue(1'b0, 1'b0, 2'b10, 64'h2004, 64'h0, 64'h8765_4321_0000_0000, 3, 1, 1'b0);
        drain();
        chk("word_load_rdata_held", rdata_o, 64'h0000_0000_8765_4321);

        issue(1'b0, 1'b1, 2'b01, 64'h11, 64'h0, 64'h0, 0, 0, 1'b0);
        @(negedge clk);
        chk("ready_in_err", {63'd0, ready}, 64'd0);
        @(negedge clk);
        chk("ready_after_mis_half", {63'd0, ready}, 64'd1);
        issue(1'b1, 1'b0, 2'b11, 64'h8004, 64'h1234, 64'h0, 0, 0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("ready_after_mis_double", {63'd0, ready}, 64'd1);
        drain();

        issue(1'b0, 1'b0, 2'b11, 64'h3000, 64'h0, 64'hFFFF_0000_1234_5678, 1, 0, 1'b0);
        drain();

        // Reset while waiting for load data, then an orphan response.
        issue(1'b0, 1'b0, 2'b11, 64'h4000, 64'h0, 64'hDEAD_BEEF_0000_1111, 0, 20, 1'b0);
        repeat (3) @(negedge clk);
        @(posedge clk); #1 rst = 1'b1;
        tq.delete(); bq.delete();
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_reset();
        orphan = 1'b1;
        @(negedge clk);
        orphan = 1'b0;
        repeat (2) @(negedge clk);
        chk("orphan_rdata", rdata_o, 64'd0);
        issue(1'b1, 1'b1, 2'b01, 64'h5006, 64'hBEEF, 64'h0, 1, 0, 1'b0);
        drain();

        issue(1'b1, 1'b0, 2'b10, 64'h6004, 64'hCAFE_F00D, 64'h0, 0, 0, 1'b1);
        issue(1'b0, 1'b1, 2'b00, 64'h6007, 64'h0, 64'h1122_3344_5566_7788, 0, 0, 1'b0);
        drain();

        spurious_en = 1'b1;
        for (int i = 0; i < 150; i++) begin
            sz = 2'($urandom_range(0, 3));
            a  = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) a = a & ~64'((1 << sz) - 1);
            issue(1'($urandom), 1'($urandom), sz, a, {$urandom, $urandom}, {$urandom, $urandom},
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), (i != 149) && ($urandom_range(0, 1) == 1));
        end
        drain();
        spurious_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
